// File: rtl/bfsk_pkg.sv
// Shared definitions for the BFSK symbol scheduler.
//   ROM_AW  : sine ROM address width
//   ROM_MID : ROM sample at address 0 (DAC midscale)
//   state_t : scheduler states; ST_PRE exists only when BFSK_PREAMBLE_EN is defined
package bfsk_pkg;

  localparam int unsigned ROM_AW  = 8;
  localparam logic [15:0] ROM_MID = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_TAIL = 2'd2
`ifdef BFSK_PREAMBLE_EN
    , ST_PRE = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/bfsk_phase_acc.sv
// Phase accumulator driving the sine ROM address.
// Ports:
//   CLOCK_50 in  clock
//   rst_n    in  async active-low reset (acc <= 0)
//   clr      in  synchronous clear, priority over en
//   en       in  advance acc by the selected step
//   sel      in  step select (1 = INC_MARK, 0 = INC_SPACE)
//   addr     out top ROM_AW bits of the accumulator
//   wrap     out the step taken this cycle carries out of ACC_W bits
module bfsk_phase_acc
  import bfsk_pkg::*;
#(
  parameter int unsigned      ACC_W     = 16,
  parameter logic [ACC_W-1:0] INC_MARK  = ACC_W'(16'h0400),
  parameter logic [ACC_W-1:0] INC_SPACE = ACC_W'(16'h0200)
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              sel,
  output logic [ROM_AW-1:0] addr,
  output logic              wrap
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, (sel ? INC_MARK : INC_SPACE)};
    wrap = en & sum[ACC_W];
    addr = acc[ACC_W-1 -: ROM_AW];
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/bfsk_symbol_scheduler.sv
// BFSK modulator front end: accepts bits over valid/ready, holds each for
// SYM_CYCLES clocks and sweeps the sine ROM with a phase-continuous accumulator.
// After the last symbol the tone runs on until the phase wraps, so the output
// always stops at ROM address 0 (midscale).
// Optional feature macro: BFSK_PREAMBLE_EN (PRE_LEN alternating symbols,
// starting with mark, before the first accepted bit).
// Ports:
//   CLOCK_50  in  clock
//   rst_n     in  async active-low reset
//   enable    in  permits acceptance of new bits
//   bit_valid in  source presents bit_data
//   bit_data  in  bit to send (1 = mark)
//   bit_ready out bit accepted at this edge when bit_valid is high
//   sin_addr  out sine ROM address
//   freq_sel  out tone of the current symbol
//   sym_start out one-cycle pulse on the first cycle of each symbol
//   busy      out not idle
module bfsk_symbol_scheduler
  import bfsk_pkg::*;
#(
  parameter int unsigned      ACC_W      = 16,
  parameter int unsigned      SYM_CYCLES = 1024,
  parameter logic [ACC_W-1:0] INC_MARK   = ACC_W'(16'h0400),
  parameter logic [ACC_W-1:0] INC_SPACE  = ACC_W'(16'h0200),
  parameter int unsigned      PRE_LEN    = 8
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              bit_valid,
  input  logic              bit_data,
  output logic              bit_ready,
  output logic [ROM_AW-1:0] sin_addr,
  output logic              freq_sel,
  output logic              sym_start,
  output logic              busy
);

  localparam int unsigned  CW       = (SYM_CYCLES > 2) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CW-1:0] SYM_LAST = CW'(SYM_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] sym_cnt, sym_cnt_n;
  logic          freq_n, start_n;
  logic          rdy, last, xfer;
  logic          acc_clr, acc_en, acc_wrap;

`ifdef BFSK_PREAMBLE_EN
  localparam int unsigned   PW       = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_LEN - 1);
  logic [PW-1:0] pre_cnt, pre_cnt_n;
  logic          bit_lat, bit_lat_n;
`endif

  always_comb begin
    state_n   = state;
    sym_cnt_n = sym_cnt;
    freq_n    = freq_sel;
    start_n   = 1'b0;
    rdy       = 1'b0;
`ifdef BFSK_PREAMBLE_EN
    pre_cnt_n = pre_cnt;
    bit_lat_n = bit_lat;
`endif
    last = (sym_cnt == SYM_LAST);

    case (state)
      ST_IDLE: rdy = enable;
      ST_SEND: rdy = enable & last;
      default: rdy = 1'b0;
    endcase
    xfer = rdy & bit_valid;

    case (state)
      ST_IDLE: begin
        if (xfer) begin
          sym_cnt_n = '0;
          start_n   = 1'b1;
`ifdef BFSK_PREAMBLE_EN
          bit_lat_n = bit_data;
          pre_cnt_n = '0;
          freq_n    = 1'b1;
          state_n   = ST_PRE;
`else
          freq_n    = bit_data;
          state_n   = ST_SEND;
`endif
        end
      end
      ST_SEND: begin
        sym_cnt_n = sym_cnt + CW'(1);
        if (last) begin
          sym_cnt_n = '0;
          if (xfer) begin
            start_n = 1'b1;
            freq_n  = bit_data;
          end else begin
            state_n = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        if (acc_wrap) state_n = ST_IDLE;
      end
`ifdef BFSK_PREAMBLE_EN
      ST_PRE: begin
        sym_cnt_n = sym_cnt + CW'(1);
        if (last) begin
          sym_cnt_n = '0;
          start_n   = 1'b1;
          if (pre_cnt == PRE_LAST) begin
            freq_n  = bit_lat;
            state_n = ST_SEND;
          end else begin
            pre_cnt_n = pre_cnt + PW'(1);
            freq_n    = ~freq_sel;
          end
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase

    // Accumulator sits at 0 while idle and is zeroed on the tail's wrap edge.
    acc_en  = (state != ST_IDLE);
    acc_clr = (state == ST_IDLE) | ((state == ST_TAIL) & acc_wrap);

    bit_ready = rdy & rst_n;
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sym_cnt   <= '0;
      freq_sel  <= 1'b0;
      sym_start <= 1'b0;
`ifdef BFSK_PREAMBLE_EN
      pre_cnt   <= '0;
      bit_lat   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      sym_cnt   <= sym_cnt_n;
      freq_sel  <= freq_n;
      sym_start <= start_n;
`ifdef BFSK_PREAMBLE_EN
      pre_cnt   <= pre_cnt_n;
      bit_lat   <= bit_lat_n;
`endif
    end
  end

  bfsk_phase_acc #(
    .ACC_W    (ACC_W),
    .INC_MARK (INC_MARK),
    .INC_SPACE(INC_SPACE)
  ) u_phase_acc (
    .CLOCK_50(CLOCK_50),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .en      (acc_en),
    .sel     (freq_sel),
    .addr    (sin_addr),
    .wrap    (acc_wrap)
  );

endmodule

// File: tb/tb_bfsk_symbol_scheduler.sv
module tb_bfsk_symbol_scheduler;

  localparam int SYM = 16;
  localparam int PRE = 8;
  localparam int LIM = 2000;
`ifdef BFSK_PREAMBLE_EN
  localparam bit USE_PRE = 1'b1;
`else
  localparam bit USE_PRE = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       rst_n, enable, bit_valid, bit_data;
  logic       bit_ready, freq_sel, sym_start, busy;
  logic [7:0] sin_addr;

  bfsk_symbol_scheduler #(.SYM_CYCLES(SYM)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .enable   (enable),
    .bit_valid(bit_valid),
    .bit_data (bit_data),
    .bit_ready(bit_ready),
    .sin_addr (sin_addr),
    .freq_sel (freq_sel),
    .sym_start(sym_start),
    .busy     (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [7:0] addr;
    logic       freq;
    logic       start;
    logic       busy;
    logic       ready;
  } exp_t;

  exp_t mq[$];      // model output
  exp_t exp_q[$];   // scoreboard consumed by the compare process
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_xfer = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input int idx, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, expv);
    end
  endtask

  function automatic int stepv(input bit f);
    return f ? 1024 : 512;
  endfunction

  // Expected per-cycle outputs from the transfer edge onward: each symbol is
  // SYM cycles of a phase ramp, then the last tone runs until phase reaches
  // 65536, then one idle cycle at address 0.
  task automatic build(input bit use_pre, input int nb, input logic [7:0] bv, input bit en_end);
    bit   syms[$];
    int   data0, ph;
    bit   f, done;
    exp_t e;
    mq.delete();
    data0 = use_pre ? PRE : 0;
    if (use_pre) for (int i = 0; i < PRE; i++) syms.push_back(i % 2 == 0);
    for (int i = 0; i < nb; i++) syms.push_back(bv[i]);
    ph = 0;
    for (int s = 0; s < syms.size(); s++) begin
      for (int k = 0; k < SYM; k++) begin
        e.addr  = 8'(ph / 256);
        e.freq  = syms[s];
        e.start = (k == 0);
        e.busy  = 1'b1;
        e.ready = (s >= data0 && k == SYM - 1) ? en_end : 1'b0;
        mq.push_back(e);
        ph = (ph + stepv(syms[s])) % 65536;
      end
    end
    f = syms[syms.size() - 1];
    done = 1'b0;
    while (!done) begin
      e.addr = 8'(ph / 256); e.freq = f; e.start = 1'b0; e.busy = 1'b1; e.ready = 1'b0;
      mq.push_back(e);
      if (ph + stepv(f) >= 65536) done = 1'b1;
      else ph = ph + stepv(f);
    end
    e.addr = 8'd0; e.freq = 1'b0; e.start = 1'b0; e.busy = 1'b0; e.ready = en_end;
    mq.push_back(e);
  endtask

  // Compare process: a transfer seen before an edge starts consumption of
  // the scoreboard on the cycle after that edge.
  initial begin : compare
    bit   active, pend;
    exp_t e;
    active = 1'b0;
    pend   = 1'b0;
    forever begin
      @(posedge CLOCK_50); #1;
      if (pend) begin
        active = 1'b1;
        n_xfer++;
      end
      if (active && rst_n) begin
        if (exp_q.size() == 0) begin
          active = 1'b0;
        end else begin
          e = exp_q.pop_front();
          chk("sin_addr", cyc, int'(sin_addr), int'(e.addr));
          chk("sym_start", cyc, int'(sym_start), int'(e.start));
          chk("busy", cyc, int'(busy), int'(e.busy));
          chk("bit_ready", cyc, int'(bit_ready), int'(e.ready));
          if (e.busy) chk("freq_sel", cyc, int'(freq_sel), int'(e.freq));
          cyc++;
          if (exp_q.size() == 0) active = 1'b0;
        end
      end
      @(negedge CLOCK_50); #2;
      pend = rst_n && bit_valid && bit_ready;
    end
  end

  // Present a bit at a negedge and hold it until the upcoming edge accepts it;
  // returns at the negedge following the transfer.
  task automatic send_bit(input bit b);
    int n;
    bit_valid = 1'b1;
    bit_data  = b;
    #1;
    n = 0;
    while (!bit_ready && n < LIM) begin
      @(negedge CLOCK_50); #1;
      n++;
    end
    if (n >= LIM) chk("ready_timeout", n, 0, 1);
    @(negedge CLOCK_50);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < LIM) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("drain_left", n, exp_q.size(), 0);
  endtask

  task automatic run_test(input int nb, input logic [7:0] bv, input int drop_at);
    build(USE_PRE, nb, bv, drop_at < 0);
    exp_q  = mq;
    n_xfer = 0;
    cyc    = 0;
    enable = 1'b1;
    for (int i = 0; i < nb; i++) send_bit(bv[i]);
    if (drop_at >= 0) begin
      bit_valid = 1'b1;
      bit_data  = 1'b0;
      repeat (drop_at) @(negedge CLOCK_50);
      enable = 1'b0;
    end else begin
      bit_valid = 1'b0;
    end
    drain();
    bit_valid = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("transfers", nb, n_xfer, nb);
    enable = 1'b1;
  endtask

  initial begin : main
    rst_n = 1'b0; enable = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    #1;
    chk("rst_addr", 0, int'(sin_addr), 0);
    chk("rst_busy", 0, int'(busy), 0);
    chk("rst_ready", 0, int'(bit_ready), 0);
    chk("rst_start", 0, int'(sym_start), 0);

    // Hand-computed pins on the model itself.
    build(1'b0, 1, 8'b1, 1'b1);
    chk("pin_mark_len", 0, mq.size(), 65);
    chk("pin_mark_a15", 0, int'(mq[15].addr), 60);
    chk("pin_mark_a16", 0, int'(mq[16].addr), 64);
    chk("pin_mark_a63", 0, int'(mq[63].addr), 252);
    chk("pin_mark_idle", 0, int'(mq[64].busy), 0);
    build(1'b0, 1, 8'b0, 1'b1);
    chk("pin_space_len", 0, mq.size(), 129);
    chk("pin_space_a15", 0, int'(mq[15].addr), 30);
    chk("pin_space_a127", 0, int'(mq[127].addr), 254);
    build(1'b0, 2, 8'b01, 1'b1);
    chk("pin_b2b_a17", 0, int'(mq[17].addr), 66);
    chk("pin_b2b_f16", 0, int'(mq[16].freq), 0);
    chk("pin_b2b_r15", 0, int'(mq[15].ready), 1);
    build(1'b1, 1, 8'b0, 1'b1);
    chk("pin_pre_f1", 0, int'(mq[16].freq), 0);
    chk("pin_pre_s128", 0, int'(mq[128].start), 1);
    chk("pin_pre_f128", 0, int'(mq[128].freq), 0);

    @(negedge CLOCK_50);
    rst_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    run_test(1, 8'b1, -1);        // single mark
    run_test(2, 8'b01, -1);       // mark then space, back-to-back
    run_test(1, 8'b1, 5);         // enable dropped mid-symbol
    run_test(1, 8'b0, -1);        // single space (preamble first if enabled)

    // Reset mid-run, with enable high so bit_ready gating is exercised.
    build(USE_PRE, 1, 8'b1, 1'b1);
    exp_q = mq;
    enable = 1'b1;
    send_bit(1'b1);
    bit_valid = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_addr", 0, int'(sin_addr), 0);
    chk("mid_rst_busy", 0, int'(busy), 0);
    chk("mid_rst_ready", 0, int'(bit_ready), 0);
    chk("mid_rst_start", 0, int'(sym_start), 0);
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(negedge CLOCK_50); #1;
    chk("post_rst_addr", 0, int'(sin_addr), 0);
    chk("post_rst_busy", 0, int'(busy), 0);
    chk("post_rst_ready", 0, int'(bit_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
